// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Runtime-programmable serial bit-pattern detector with a saturating
//   match counter. Comes out of reset as the legacy b1010 overlapping
//   detector.
//
// Ports
//   clk          in   clock
//   resetn       in   synchronous active-low reset
//   din          in   serial input bit
//   din_valid    in   din is sampled only when high
//   cfg_we       in   one-cycle configuration load strobe
//   cfg_pattern  in   pattern; bit [cfg_len-1] oldest, bit [0] newest
//   cfg_len      in   pattern length, legal 1..MAX_LEN
//   cfg_overlap  in   1 = overlapping matches, 0 = history cleared on match
//   cnt_clr      in   clears match_count (wins over an increment)
//   dout         out  registered one-cycle pulse per match
//   match_count  out  saturating match counter
//   cfg_err      out  registered one-cycle pulse on a rejected cfg write
module seq_detect_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_dout;
  logic [CNT_W-1:0]   r_match_count;
  logic               r_cfg_err;

  logic               w_len_ok;
  logic               w_cfg_load;
  logic               w_sample;
  logic [MAX_LEN-1:0] w_hist_sh;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;

  assign w_len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_cfg_load = cfg_we && w_len_ok;
  // A rejected configuration write leaves the sample path untouched.
  assign w_sample   = din_valid && !w_cfg_load;
  assign w_hist_sh  = {r_hist[MAX_LEN-2:0], din};
  assign w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);

  // Selects the low r_len bits of the history for comparison.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
  end

  assign w_match = w_sample && (w_fill_inc >= r_len) &&
                   (((w_hist_sh ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hist        <= '0;
      r_fill        <= '0;
      r_pat         <= MAX_LEN'(4'b1010);
      r_len         <= LEN_W'(4);
      r_ovl         <= 1'b1;
      r_dout        <= 1'b0;
      r_match_count <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_dout    <= w_match;
      r_cfg_err <= cfg_we && !w_len_ok;

      if (w_cfg_load) begin
        r_pat  <= cfg_pattern;
        r_len  <= cfg_len;
        r_ovl  <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
      end else if (din_valid) begin
        r_hist <= w_hist_sh;
        // Non-overlap: zero fill so a new match needs r_len fresh bits.
        r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
      end

      if (cnt_clr) begin
        r_match_count <= '0;
      end else if (w_match && (r_match_count != '1)) begin
        r_match_count <= r_match_count + CNT_W'(1);
      end
    end
  end

  assign dout        = r_dout;
  assign match_count = r_match_count;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               resetn;
  logic               din;
  logic               din_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .dout        (dout),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  // Reference model: a queue of the valid bits seen since the last history
  // clear, newest at the back, capped at MAX_LEN entries.
  bit               mq[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  int               m_cnt;
  bit               m_dout;
  bit               m_err;

  task automatic model_edge(input bit rn, input bit we, input logic [MAX_LEN-1:0] p,
                            input int l, input bit o, input bit clr, input bit v, input bit d);
    bit hit;
    bit legal;
    hit = 0;
    if (!rn) begin
      mq.delete();
      m_pat  = 8'b0000_1010;
      m_len  = 4;
      m_ovl  = 1;
      m_cnt  = 0;
      m_dout = 0;
      m_err  = 0;
    end else begin
      legal = (l >= 1) && (l <= MAX_LEN);
      m_err = we && !legal;
      if (we && legal) begin
        m_pat = p;
        m_len = l;
        m_ovl = o;
        mq.delete();
      end else if (v) begin
        mq.push_back(d);
        if (mq.size() > MAX_LEN) void'(mq.pop_front());
        if (mq.size() >= m_len) begin
          hit = 1;
          for (int i = 0; i < m_len; i++)
            if (mq[mq.size() - 1 - i] != m_pat[i]) hit = 0;
        end
        if (hit && !m_ovl) mq.delete();
      end
      m_dout = hit;
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs, advance the model, and compare after the edge.
  task automatic cycle(input bit rn, input bit we, input logic [MAX_LEN-1:0] p,
                       input int l, input bit o, input bit clr, input bit v, input bit d);
    resetn      = rn;
    cfg_we      = we;
    cfg_pattern = p;
    cfg_len     = LEN_W'(l);
    cfg_overlap = o;
    cnt_clr     = clr;
    din_valid   = v;
    din         = d;
    model_edge(rn, we, p, l, o, clr, v, d);
    @(posedge clk);
    #1;
    check("model dout", 32'(dout), 32'(m_dout));
    check("model match_count", 32'(match_count), 32'(m_cnt));
    check("model cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  typedef struct {
    bit               rn, we;
    logic [MAX_LEN-1:0] p;
    int               l;
    bit               o, clr, v, d;
    bit               e_dout;
    int               e_cnt;
    bit               e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(bit rn, bit we, logic [MAX_LEN-1:0] p, int l, bit o, bit clr,
                             bit v, bit d, bit ed, int ec, bit ee);
    vec_t r;
    r.rn = rn; r.we = we; r.p = p; r.l = l; r.o = o; r.clr = clr;
    r.v = v; r.d = d; r.e_dout = ed; r.e_cnt = ec; r.e_err = ee;
    return r;
  endfunction

  function automatic vec_t D(bit d, bit ed, int ec);
    return V(1, 0, '0, 0, 0, 0, 1, d, ed, ec, 0);
  endfunction

  initial begin
    // Reset
    tbl.push_back(V(0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, '0, 0, 0, 0, 1, 1, 0, 0, 0));
    // Default b1010, overlapping
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 0, 0));
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 1, 1));
    tbl.push_back(D(1, 0, 1)); tbl.push_back(D(0, 1, 2));
    // Non-overlap b1010 (counter cleared on the cfg edge; din discarded)
    tbl.push_back(V(1, 1, 8'h0A, 4, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 0, 0));
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 1, 1));
    tbl.push_back(D(1, 0, 1)); tbl.push_back(D(0, 0, 1));
    tbl.push_back(D(1, 0, 1)); tbl.push_back(D(0, 1, 2));
    // Reprogram b110 with valid gaps
    tbl.push_back(V(1, 1, 8'b110, 3, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(D(1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(V(1, 0, '0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 1, 1));
    tbl.push_back(V(1, 0, '0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Reset mid-pattern (reset restores b1010)
    tbl.push_back(D(1, 0, 1)); tbl.push_back(D(0, 0, 1)); tbl.push_back(D(1, 0, 1));
    tbl.push_back(V(0, 0, '0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(D(0, 0, 0));
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 0, 0));
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 1, 1));
    // Saturation with len 1, then clear concurrent with a match
    tbl.push_back(V(1, 1, 8'h01, 1, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(D(1, 1, 1)); tbl.push_back(D(1, 1, 2)); tbl.push_back(D(1, 1, 3));
    tbl.push_back(D(1, 1, 3)); tbl.push_back(D(1, 1, 3)); tbl.push_back(D(1, 1, 3));
    tbl.push_back(V(1, 0, '0, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(D(0, 0, 0));
    // Illegal config writes leave b1010 overlapping detection running
    tbl.push_back(V(1, 1, 8'h0A, 4, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(D(1, 0, 0)); tbl.push_back(D(0, 0, 0));
    tbl.push_back(V(1, 1, 8'hFF, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(D(0, 1, 1));
    tbl.push_back(V(1, 1, 8'h00, MAX_LEN + 1, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(D(0, 1, 2));

    foreach (tbl[i]) begin
      cycle(tbl[i].rn, tbl[i].we, tbl[i].p, tbl[i].l, tbl[i].o,
            tbl[i].clr, tbl[i].v, tbl[i].d);
      check($sformatf("row%0d dout", i), 32'(dout), 32'(tbl[i].e_dout));
      check($sformatf("row%0d match_count", i), 32'(match_count), 32'(tbl[i].e_cnt));
      check($sformatf("row%0d cfg_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit rn, we, o, clr, v, d;
      int l;
      logic [MAX_LEN-1:0] p;
      rn  = ($urandom_range(0, 199) != 0);
      we  = ($urandom_range(0, 39) == 0);
      l   = $urandom_range(0, 9);
      p   = MAX_LEN'($urandom);
      o   = 1'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      cycle(rn, we, p, l, o, clr, v, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
